// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command front-end: FSM encodings and the
// ALU function codes the host is expected to issue.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [5:0] ALUFN_ADD   = 6'b000000;
    localparam logic [5:0] ALUFN_SUB   = 6'b000001;
    localparam logic [5:0] ALUFN_MUL   = 6'b000010;
    localparam logic [5:0] ALUFN_SHL   = 6'b100000;
    localparam logic [5:0] ALUFN_CMPEQ = 6'b110011;

endpackage

// File: rtl/alu_seq_if.sv
// Host-side request/response bundle of the ALU front-end.
// master = host issuing operations, slave = alu_seq.
interface alu_seq_if #(
    parameter int WIDTH = 32
) ();

    logic             req_valid;
    logic             req_ready;
    logic [5:0]       req_alufn;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_use_acc;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_z;
    logic             rsp_n;
    logic             rsp_v;

    modport master (
        output req_valid, req_alufn, req_a, req_b, req_use_acc, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_z, rsp_n, rsp_v
    );

    modport slave (
        input  req_valid, req_alufn, req_a, req_b, req_use_acc, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_z, rsp_n, rsp_v
    );

endinterface

// File: rtl/alu_seq.sv
// Sequential front-end for an externally instantiated combinational ALU.
// Registers one operation, lets the ALU settle for a cycle, captures the
// result and flags, and hands them back over a valid/ready response.
// An accumulator holds the last result so operations can be chained.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | req_ready=1; a valid request latches operands into alu_* regs
//   EXEC  | ALU settles on registered operands; result/acc/count captured
//   RESP  | rsp_valid=1, response held until rsp_ready
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_seq_if.slave         bus,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [5:0]       o_alu_alufn,
    input  logic [WIDTH-1:0] i_alu_out,
    input  logic             i_alu_z,
    input  logic             i_alu_n,
    input  logic             i_alu_v,
    output logic [CNT_W-1:0] o_op_count
);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_exec;

    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [5:0]       r_alu_alufn;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_z;
    logic             r_rsp_n;
    logic             r_rsp_v;
    logic [CNT_W-1:0] r_op_count;

    // Next-state decode; response handshake only matters in RESP, request only in IDLE
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_exec       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_exec       = 1'b1;
                w_next_state = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register; ready/valid are registered decodes of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_req_ready <= (w_next_state == IDLE);
            r_rsp_valid <= (w_next_state == RESP);
        end
    end

    // Operand registers driving the ALU; held after EXEC until the next accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_alufn <= '0;
        end else if (w_accept) begin
            r_alu_a     <= bus.req_use_acc ? r_acc : bus.req_a;
            r_alu_b     <= bus.req_b;
            r_alu_alufn <= bus.req_alufn;
        end
    end

    // Result capture at the end of EXEC; flags taken as-is for every function
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_rsp_data <= '0;
            r_rsp_z    <= 1'b0;
            r_rsp_n    <= 1'b0;
            r_rsp_v    <= 1'b0;
        end else if (w_exec) begin
            r_acc      <= i_alu_out;
            r_rsp_data <= i_alu_out;
            r_rsp_z    <= i_alu_z;
            r_rsp_n    <= i_alu_n;
            r_rsp_v    <= i_alu_v;
        end
    end

    // Completed-operation counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_exec) begin
            r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_z     = r_rsp_z;
    assign bus.rsp_n     = r_rsp_n;
    assign bus.rsp_v     = r_rsp_v;
    assign o_alu_a       = r_alu_a;
    assign o_alu_b       = r_alu_b;
    assign o_alu_alufn   = r_alu_alufn;
    assign o_op_count    = r_op_count;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq with a behavioural ALU attached. Stimulus pushes the
// expected response into a queue; a monitor pops and compares on every
// response handshake.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(WIDTH)) bus_if ();

    logic [WIDTH-1:0] alu_a, alu_b, alu_out, alu_sum;
    logic [5:0]       alu_alufn;
    logic             alu_z, alu_n, alu_v;
    logic [CNT_W-1:0] op_count;

    alu_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_alufn (alu_alufn),
        .i_alu_out   (alu_out),
        .i_alu_z     (alu_z),
        .i_alu_n     (alu_n),
        .i_alu_v     (alu_v),
        .o_op_count  (op_count)
    );

    // Behavioural ALU: flags always come from the adder/subtractor (alufn[0] = subtract)
    always_comb begin
        alu_sum = alu_alufn[0] ? (alu_a - alu_b) : (alu_a + alu_b);
        alu_z   = (alu_sum == '0);
        alu_n   = alu_sum[WIDTH-1];
        alu_v   = alu_alufn[0]
                ? ((alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_sum[WIDTH-1] != alu_a[WIDTH-1]))
                : ((alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_sum[WIDTH-1] != alu_a[WIDTH-1]));
        case (alu_alufn)
            ALUFN_ADD, ALUFN_SUB: alu_out = alu_sum;
            ALUFN_MUL:            alu_out = alu_a * alu_b;
            ALUFN_SHL:            alu_out = alu_a << alu_b[4:0];
            ALUFN_CMPEQ:          alu_out = {{(WIDTH-1){1'b0}}, (alu_a == alu_b)};
            default:              alu_out = '0;
        endcase
    end

    typedef struct {
        logic [31:0] data;
        logic [31:0] flags;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec   = 0;
    int   n_err   = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: compares every accepted response against the queue head
    always @(negedge clk) begin
        if (!rst && bus_if.rsp_valid && bus_if.rsp_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got data 0x%08h expected no response", bus_if.rsp_data);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_data", bus_if.rsp_data, mon_e.data);
                chk("rsp_flags_znv", 32'({bus_if.rsp_z, bus_if.rsp_n, bus_if.rsp_v}), mon_e.flags);
                chk("op_count", 32'(op_count), mon_e.cnt);
            end
        end
    end

    task automatic push_exp(input logic [31:0] d, input logic [2:0] f);
        exp_cnt++;
        sb.push_back('{data: d, flags: 32'(f), cnt: 32'(exp_cnt % 16)});
    endtask

    // Present a request mid-cycle and hold it until accepted; returns 1 after the accepting edge
    task automatic send(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic ua);
        logic rdy;
        int   t;
        t = 0;
        bus_if.req_alufn   = fn;
        bus_if.req_a       = a;
        bus_if.req_b       = b;
        bus_if.req_use_acc = ua;
        bus_if.req_valid   = 1'b1;
        rdy = bus_if.req_ready;
        @(posedge clk);
        while (!rdy && t < 20) begin
            rdy = bus_if.req_ready;
            @(posedge clk);
            t++;
        end
        if (!rdy) begin
            n_vec++;
            n_err++;
            $display("FAIL req_ready_timeout: got req_ready 0 expected 1 within 20 cycles");
        end
        #1;
        bus_if.req_valid = 1'b0;
    endtask

    // Full operation with rsp_ready high; also checks cycle-by-cycle latency
    task automatic op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                      input logic ua, input logic [31:0] exp_d, input logic [2:0] exp_f);
        push_exp(exp_d, exp_f);
        send(fn, a, b, ua);
        @(negedge clk);
        chk("exec_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("exec_req_ready", 32'(bus_if.req_ready), 32'd0);
        @(negedge clk);
        chk("resp_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus_if.req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  bus_if.rsp_data, 32'd0);
        chk({tag, "_rsp_znv"},   32'({bus_if.rsp_z, bus_if.rsp_n, bus_if.rsp_v}), 32'd0);
        chk({tag, "_alu_a"},     alu_a, 32'd0);
        chk({tag, "_alu_b"},     alu_b, 32'd0);
        chk({tag, "_alu_alufn"}, 32'(alu_alufn), 32'd0);
        chk({tag, "_op_count"},  32'(op_count), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                = 1'b1;
        bus_if.req_valid   = 1'b0;
        bus_if.req_alufn   = '0;
        bus_if.req_a       = '0;
        bus_if.req_b       = '0;
        bus_if.req_use_acc = 1'b0;
        bus_if.rsp_ready   = 1'b1;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        op(ALUFN_ADD,   32'd5,          32'd7,  1'b0, 32'd12,         3'b000);
        op(ALUFN_SUB,   32'd5,          32'd7,  1'b0, 32'hFFFF_FFFE,  3'b010);
        op(ALUFN_ADD,   32'd3,          32'd4,  1'b0, 32'd7,          3'b000);
        op(ALUFN_MUL,   32'hDEAD_BEEF,  32'd6,  1'b1, 32'd42,         3'b000);
        op(ALUFN_SUB,   32'd0,          32'd42, 1'b1, 32'd0,          3'b100);
        op(ALUFN_SHL,   32'd3,          32'd4,  1'b0, 32'd48,         3'b000);
        op(ALUFN_CMPEQ, 32'd9,          32'd9,  1'b0, 32'd1,          3'b100);
        op(ALUFN_ADD,   32'h7FFF_FFFF,  32'd1,  1'b0, 32'h8000_0000,  3'b011);

        // Backpressure: response held for 5 stalled cycles, stray request ignored
        bus_if.rsp_ready = 1'b0;
        push_exp(32'd30, 3'b000);
        send(ALUFN_ADD, 32'd10, 32'd20, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("bp_rsp_valid_enter", 32'(bus_if.rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                bus_if.req_alufn = ALUFN_ADD;
                bus_if.req_a     = 32'd1000;
                bus_if.req_b     = 32'd1000;
                bus_if.req_valid = 1'b1;
            end else begin
                bus_if.req_valid = 1'b0;
            end
            @(negedge clk);
            chk("bp_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
            chk("bp_rsp_data",  bus_if.rsp_data, 32'd30);
            chk("bp_req_ready", 32'(bus_if.req_ready), 32'd0);
            chk("bp_op_count",  32'(op_count), 32'd9);
        end
        @(posedge clk);
        #1;
        bus_if.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_req_ready", 32'(bus_if.req_ready), 32'd1);
        op(ALUFN_ADD, 32'd1, 32'd1, 1'b0, 32'd2, 3'b000);

        // Counter wrap: 17 operations from reset leave the 4-bit count at 1
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            op(ALUFN_ADD, 32'(i), 32'd1, 1'b0, 32'(i + 1), 3'b000);
        end
        chk("wrap_op_count", 32'(op_count), 32'd1);

        // Reset during EXEC drops the operation and clears acc and the count
        send(ALUFN_ADD, 32'd100, 32'd1, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midop");
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        chk("midop_no_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        op(ALUFN_ADD, 32'h55, 32'd9, 1'b1, 32'd9, 3'b000);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
